// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and types.
//   F3_*          load/store funct3 size/sign encodings
//   dmem_state_t  data-memory access controller FSM states
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for loads and stores.
//   funct3      access size/sign
//   offset      byte offset within the word (addr[1:0])
//   store_data  raw store data from the register file
//   read_word   word returned by data memory
//   wstrb       byte strobes for a store
//   wdata       store data replicated onto every lane it may land in
//   load_data   selected and sign/zero-extended load result
//   misalign    access crosses its natural alignment
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic        is_b;
    logic        is_h;
    logic        sext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Only funct3[1:0] picks the size; the reserved codes 011/110/111 fall to word.
    always_comb begin
        is_b      = funct3[1:0] == F3_B[1:0];
        is_h      = funct3[1:0] == F3_H[1:0];
        sext      = ~funct3[2];
        rbyte     = read_word[{offset, 3'b000} +: 8];
        rhalf     = offset[1] ? read_word[31:16] : read_word[15:0];
        misalign  = is_h ? offset[0] : (!is_b && offset != 2'b00);
        wstrb     = is_b ? 4'b0001 << offset : is_h ? 4'b0011 << {offset[1], 1'b0} : 4'b1111;
        wdata     = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
        load_data = is_b ? {{24{sext & rbyte[7]}}, rbyte}
                  : is_h ? {{16{sext & rhalf[15]}}, rhalf}
                  : read_word;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access controller.
//   clk, rst                      clock, synchronous active-high reset
//   ex_mem_*                      EX/MEM register outputs (MemRead/MemWrite, funct3, address, store data)
//   D_core_wait                   freezes EX/MEM and upstream until the access completes
//   load_data                     extended load result for MEM/WB
//   misalign                      one-cycle pulse when a misaligned access is dropped
//   dm_req/we/addr/wstrb/wdata    valid/ready request channel to data memory
//   dm_ready                      request accepted
//   dm_rvalid, dm_rdata           response (read data or write ack)
module dmem_access_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_wdata,
    output logic        D_core_wait,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    dmem_state_t state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic [3:0]  strb;
    logic [31:0] wdat;
    logic [31:0] ext;
    logic        mis;
    logic        go;

    // One aligner serves both directions: it sees the live instruction in IDLE
    // (store lanes, misalign) and the latched size/offset afterwards (load extend).
    assign go          = ex_mem_memread | ex_mem_memwrite;
    assign f3_sel      = state == IDLE ? ex_mem_funct3 : f3_q;
    assign off_sel     = state == IDLE ? ex_mem_addr[1:0] : off_q;
    assign D_core_wait = (state == IDLE && go) || state == REQ || state == RESP;
    assign dm_req      = state == REQ;

    lsu_align u_align (
        .funct3     (f3_sel),
        .offset     (off_sel),
        .store_data (ex_mem_wdata),
        .read_word  (dm_rdata),
        .wstrb      (strb),
        .wdata      (wdat),
        .load_data  (ext),
        .misalign   (mis)
    );

    // DONE always returns to IDLE so the instruction still sitting in EX/MEM
    // during DONE cannot start a second access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            misalign  <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wstrb  <= '0;
            dm_wdata  <= '0;
            load_data <= '0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    dm_we    <= ex_mem_memwrite;
                    dm_addr  <= {ex_mem_addr[31:2], 2'b00};
                    dm_wstrb <= ex_mem_memwrite ? strb : 4'b0000;
                    dm_wdata <= wdat;
                    f3_q     <= ex_mem_funct3;
                    off_q    <= ex_mem_addr[1:0];
                    misalign <= mis;
                    state    <= mis ? DONE : REQ;
                    if (mis) load_data <= '0;
                end
                REQ: if (dm_ready) state <= RESP;
                RESP: if (dm_rvalid) begin
                    if (!dm_we) load_data <= ext;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
